// File: rtl/dma_desc_arb.sv
// Descriptor arbiter: PORTS requesters share one DMA engine, in-flight ops capped at OP_LIMIT,
// completion status demuxed back by tag MSBs. Define DMA_DESC_ARB_FIXED_PRIO_EN for fixed priority.

module dma_desc_arb_status_lane #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [TAG_W-1:0] tag,
  input  logic [3:0]       err,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [3:0]       err_o
);
  logic             valid_q, valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [3:0]       err_q, err_d;

  // Fields hold their last routed value; only the valid strobe is a pulse.
  always_comb begin
    valid_d = sel;
    tag_d   = tag_q;
    err_d   = err_q;
    if (sel) begin
      tag_d = tag;
      err_d = err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      err_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign err_o   = err_q;
endmodule

module dma_desc_arb #(
  parameter int PORTS       = 4,
  parameter int ADDR_WIDTH  = 64,
  parameter int LEN_WIDTH   = 16,
  parameter int S_TAG_WIDTH = 8,
  parameter int OP_LIMIT    = 16,
  localparam int PW          = $clog2(PORTS),
  localparam int M_TAG_WIDTH = S_TAG_WIDTH + PW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORTS*ADDR_WIDTH-1:0]  s_desc_addr,
  input  logic [PORTS*LEN_WIDTH-1:0]   s_desc_len,
  input  logic [PORTS*S_TAG_WIDTH-1:0] s_desc_tag,
  input  logic [PORTS-1:0]             s_desc_valid,
  output logic [PORTS-1:0]             s_desc_ready,
  output logic [ADDR_WIDTH-1:0]        m_desc_addr,
  output logic [LEN_WIDTH-1:0]         m_desc_len,
  output logic [M_TAG_WIDTH-1:0]       m_desc_tag,
  output logic                         m_desc_valid,
  input  logic                         m_desc_ready,
  input  logic [M_TAG_WIDTH-1:0]       s_status_tag,
  input  logic [3:0]                   s_status_error,
  input  logic                         s_status_valid,
  output logic [PORTS*S_TAG_WIDTH-1:0] m_status_tag,
  output logic [PORTS*4-1:0]           m_status_error,
  output logic [PORTS-1:0]             m_status_valid,
  input  logic                         enable,
  output logic                         busy,
  output logic [7:0]                   outstanding
);
  localparam logic [7:0] OP_LIM = 8'(OP_LIMIT);

  logic                   m_valid_q, m_valid_d;
  logic [ADDR_WIDTH-1:0]  m_addr_q, m_addr_d;
  logic [LEN_WIDTH-1:0]   m_len_q, m_len_d;
  logic [M_TAG_WIDTH-1:0] m_tag_q, m_tag_d;
  logic [7:0]             outstanding_q, outstanding_d;

  logic                   accept, gnt_any, gnt, st_dec;
  logic [PW-1:0]          gnt_idx;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [LEN_WIDTH-1:0]   sel_len;
  logic [S_TAG_WIDTH-1:0] sel_tag;
  logic [PW-1:0]          st_port;
  logic [S_TAG_WIDTH-1:0] st_low;

`ifndef DMA_DESC_ARB_FIXED_PRIO_EN
  logic [PW-1:0] last_grant_q, last_grant_d;
  logic [PW-1:0] cand_idx;
  int            cand;
`endif

  // A status retiring this cycle frees a slot, so a full arbiter may still grant.
  assign accept = !rst && enable && (!m_valid_q || m_desc_ready) &&
                  ((outstanding_q < OP_LIM) || s_status_valid);

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
`ifdef DMA_DESC_ARB_FIXED_PRIO_EN
    for (int i = 0; i < PORTS; i++) begin
      if (!gnt_any && s_desc_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(i);
      end
    end
`else
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= PORTS; i++) begin
      cand = int'(last_grant_q) + i;
      if (cand >= PORTS) cand = cand - PORTS;
      cand_idx = PW'(cand);
      if (!gnt_any && s_desc_valid[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
`endif
  end

  assign gnt = accept && gnt_any;

  always_comb begin
    s_desc_ready = '0;
    sel_addr     = '0;
    sel_len      = '0;
    sel_tag      = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (gnt_idx == PW'(p)) begin
        sel_addr        = s_desc_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len         = s_desc_len[p*LEN_WIDTH +: LEN_WIDTH];
        sel_tag         = s_desc_tag[p*S_TAG_WIDTH +: S_TAG_WIDTH];
        s_desc_ready[p] = gnt;
      end
    end
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_addr_d  = m_addr_q;
    m_len_d   = m_len_q;
    m_tag_d   = m_tag_q;
    if (gnt) begin
      m_valid_d = 1'b1;
      m_addr_d  = sel_addr;
      m_len_d   = sel_len;
      m_tag_d   = {gnt_idx, sel_tag};
    end else if (m_desc_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Unmatched status at zero count is still routed but must not wrap the counter.
  assign st_dec        = s_status_valid && (outstanding_q != 8'd0);
  assign outstanding_d = outstanding_q + 8'(gnt) - 8'(st_dec);

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q     <= 1'b0;
      m_addr_q      <= '0;
      m_len_q       <= '0;
      m_tag_q       <= '0;
      outstanding_q <= '0;
    end else begin
      m_valid_q     <= m_valid_d;
      m_addr_q      <= m_addr_d;
      m_len_q       <= m_len_d;
      m_tag_q       <= m_tag_d;
      outstanding_q <= outstanding_d;
    end
  end

`ifndef DMA_DESC_ARB_FIXED_PRIO_EN
  assign last_grant_d = gnt ? gnt_idx : last_grant_q;

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= PW'(PORTS - 1);
    else     last_grant_q <= last_grant_d;
  end
`endif

  assign st_port = s_status_tag[M_TAG_WIDTH-1 -: PW];
  assign st_low  = s_status_tag[S_TAG_WIDTH-1:0];

  // Port indices >= PORTS match no lane and are dropped here.
  for (genvar p = 0; p < PORTS; p++) begin : g_lane
    dma_desc_arb_status_lane #(.TAG_W(S_TAG_WIDTH)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .sel     (s_status_valid && (st_port == PW'(p))),
      .tag     (st_low),
      .err     (s_status_error),
      .valid_o (m_status_valid[p]),
      .tag_o   (m_status_tag[p*S_TAG_WIDTH +: S_TAG_WIDTH]),
      .err_o   (m_status_error[p*4 +: 4])
    );
  end

  assign m_desc_valid = m_valid_q;
  assign m_desc_addr  = m_addr_q;
  assign m_desc_len   = m_len_q;
  assign m_desc_tag   = m_tag_q;
  assign outstanding  = outstanding_q;
  assign busy         = m_valid_q | (outstanding_q != 8'd0);
endmodule

// File: tb/tb_dma_desc_arb.sv
// Bench for dma_desc_arb: transaction model checked every negedge plus directed literal checks.
module tb_dma_desc_arb;
  localparam int P = 4, AW = 64, LW = 16, SW = 8, OPL = 16, PW = 2, MW = 10;

  logic clk = 1'b0, rst = 1'b1;
  logic [P*AW-1:0] s_desc_addr;
  logic [P*LW-1:0] s_desc_len;
  logic [P*SW-1:0] s_desc_tag;
  logic [P-1:0]    s_desc_valid, s_desc_ready;
  logic [AW-1:0]   m_desc_addr;
  logic [LW-1:0]   m_desc_len;
  logic [MW-1:0]   m_desc_tag;
  logic            m_desc_valid, m_desc_ready;
  logic [MW-1:0]   s_status_tag;
  logic [3:0]      s_status_error;
  logic            s_status_valid;
  logic [P*SW-1:0] m_status_tag;
  logic [P*4-1:0]  m_status_error;
  logic [P-1:0]    m_status_valid;
  logic            enable, busy;
  logic [7:0]      outstanding;

  dma_desc_arb #(.PORTS(P), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .S_TAG_WIDTH(SW), .OP_LIMIT(OPL)) dut (
    .clk(clk), .rst(rst),
    .s_desc_addr(s_desc_addr), .s_desc_len(s_desc_len), .s_desc_tag(s_desc_tag),
    .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
    .m_desc_addr(m_desc_addr), .m_desc_len(m_desc_len), .m_desc_tag(m_desc_tag),
    .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
    .s_status_tag(s_status_tag), .s_status_error(s_status_error), .s_status_valid(s_status_valid),
    .m_status_tag(m_status_tag), .m_status_error(m_status_error), .m_status_valid(m_status_valid),
    .enable(enable), .busy(busy), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int gq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the registered outputs must show after the next rising edge.
  bit            started = 1'b0;
  int            e_out, e_last;
  bit            e_mv;
  logic [AW-1:0] e_addr;
  logic [LW-1:0] e_len;
  logic [MW-1:0] e_tag;
  logic [P-1:0]  e_sv;
  logic [SW-1:0] e_st [P];
  logic [3:0]    e_se [P];

  always @(negedge clk) begin
    int pick, np, nw;
    bit acc;
    logic [P-1:0]    er;
    logic [P*SW-1:0] est;
    logic [P*4-1:0]  ese;
    pick = -1;
`ifdef DMA_DESC_ARB_FIXED_PRIO_EN
    for (int k = 0; k < P; k++) if (pick < 0 && s_desc_valid[k]) pick = k;
`else
    for (int k = 1; k <= P; k++) if (pick < 0 && s_desc_valid[(e_last + k) % P]) pick = (e_last + k) % P;
`endif
    acc = !rst && enable && (!e_mv || m_desc_ready) && (e_out < OPL || s_status_valid);
    er = '0;
    if (acc && pick >= 0) er[pick] = 1'b1;
    for (int k = 0; k < P; k++) if (s_desc_ready[k]) gq.push_back(k);
    if (started) begin
      for (int k = 0; k < P; k++) begin
        est[k*SW +: SW] = e_st[k];
        ese[k*4 +: 4]   = e_se[k];
      end
      chk("s_desc_ready", 64'(s_desc_ready), 64'(er));
      chk("m_desc_valid", 64'(m_desc_valid), 64'(e_mv));
      chk("m_desc_addr", m_desc_addr, e_addr);
      chk("m_desc_len", 64'(m_desc_len), 64'(e_len));
      chk("m_desc_tag", 64'(m_desc_tag), 64'(e_tag));
      chk("outstanding", 64'(outstanding), 64'(e_out));
      chk("busy", 64'(busy), 64'(e_mv || e_out != 0));
      chk("m_status_valid", 64'(m_status_valid), 64'(e_sv));
      chk("m_status_tag", 64'(m_status_tag), 64'(est));
      chk("m_status_error", 64'(m_status_error), 64'(ese));
    end
    if (rst) begin
      started = 1'b1;
      e_out = 0; e_last = P - 1; e_mv = 1'b0;
      e_addr = '0; e_len = '0; e_tag = '0; e_sv = '0;
      for (int k = 0; k < P; k++) begin e_st[k] = '0; e_se[k] = '0; end
    end else begin
      nw = e_out;
      if (acc && pick >= 0) begin
        e_mv   = 1'b1;
        e_addr = s_desc_addr[pick*AW +: AW];
        e_len  = s_desc_len[pick*LW +: LW];
        e_tag  = {PW'(pick), s_desc_tag[pick*SW +: SW]};
        e_last = pick;
        nw++;
      end else if (m_desc_ready) begin
        e_mv = 1'b0;
      end
      if (s_status_valid && e_out > 0) nw--;
      e_out = nw;
      e_sv = '0;
      if (s_status_valid) begin
        np = int'(s_status_tag[MW-1:SW]);
        if (np < P) begin
          e_sv[np] = 1'b1;
          e_st[np] = s_status_tag[SW-1:0];
          e_se[np] = s_status_error;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic status(input int port, input logic [7:0] tag, input logic [3:0] err);
    s_status_tag   = {PW'(port), tag};
    s_status_error = err;
    s_status_valid = 1'b1;
    step();
    s_status_valid = 1'b0;
  endtask

  initial begin
    enable = 1'b1; m_desc_ready = 1'b1; s_desc_valid = '0;
    s_status_tag = '0; s_status_error = '0; s_status_valid = 1'b0;
    for (int p = 0; p < P; p++) begin
      s_desc_addr[p*AW +: AW] = {32'hDEAD0000 + 32'(p), 32'h1000 * 32'(p + 1)};
      s_desc_len[p*LW +: LW]  = 16'h0100 + 16'(p);
      s_desc_tag[p*SW +: SW]  = 8'h10 + 8'(p);
    end
    // Reset: ready must stay low even with every port requesting.
    rst = 1'b1;
    s_desc_valid = 4'hF;
    repeat (3) step();
    chk("rst_ready", 64'(s_desc_ready), 64'h0);
    chk("rst_mvalid", 64'(m_desc_valid), 64'h0);
    chk("rst_outstanding", 64'(outstanding), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_svalid", 64'(m_status_valid), 64'h0);
    chk("rst_mtag", 64'(m_desc_tag), 64'h0);

    // All ports valid, no status: 16 grants in round-robin order then stall.
    rst = 1'b0;
    repeat (20) step();
    chk("rr_count", 64'(gq.size()), 64'd16);
`ifndef DMA_DESC_ARB_FIXED_PRIO_EN
    for (int i = 0; i < gq.size(); i++) chk($sformatf("rr_order%0d", i), 64'(gq[i]), 64'(i % 4));
`endif
    chk("full_outstanding", 64'(outstanding), 64'd16);
    chk("full_ready", 64'(s_desc_ready), 64'h0);
    chk("full_busy", 64'(busy), 64'h1);

    // At the limit, a concurrent status lets a new grant through.
    s_desc_valid = 4'b0010;
    s_status_tag = {2'd0, 8'h77}; s_status_error = 4'h1; s_status_valid = 1'b1;
    #1 chk("lim_ready", 64'(s_desc_ready), 64'b0010);
    step();
    s_desc_valid = '0; s_status_valid = 1'b0;
    chk("lim_outstanding", 64'(outstanding), 64'd16);
    chk("lim_svalid", 64'(m_status_valid), 64'b0001);
    chk("lim_stag0", 64'(m_status_tag[7:0]), 64'h77);
    chk("lim_mtag", 64'(m_desc_tag), 64'h111);
    for (int i = 0; i < 16; i++) status(i % 4, 8'(i), 4'(i));
    step();
    chk("drain_outstanding", 64'(outstanding), 64'd0);

    // Port 2 tag 0x5A round trip.
    s_desc_tag[2*SW +: SW] = 8'h5A;
    s_desc_valid = 4'b0100;
    step();
    s_desc_valid = '0;
    chk("p2_mtag", 64'(m_desc_tag), 64'h25A);
    chk("p2_outstanding", 64'(outstanding), 64'd1);
    step();
    status(2, 8'h5A, 4'h3);
    chk("p2_svalid", 64'(m_status_valid), 64'b0100);
    chk("p2_stag", 64'(m_status_tag[23:16]), 64'h5A);
    chk("p2_serr", 64'(m_status_error[11:8]), 64'h3);
    chk("p2_outstanding0", 64'(outstanding), 64'd0);
    step();
    chk("p2_pulse", 64'(m_status_valid), 64'h0);
    chk("p2_hold", 64'(m_status_tag[23:16]), 64'h5A);

    // Engine back-pressure for 5 cycles, then exactly one more transfer.
    m_desc_ready = 1'b0;
    s_desc_valid = 4'b0001;
    step();
    s_desc_valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_ready", 64'(s_desc_ready), 64'h0);
      chk("bp_mvalid", 64'(m_desc_valid), 64'h1);
      chk("bp_addr", m_desc_addr, 64'hDEAD0000_00001000);
      step();
    end
    m_desc_ready = 1'b1;
    #1 chk("bp_release", 64'(s_desc_ready), 64'b1000);
    step();
    s_desc_valid = '0;
    chk("bp_mtag", 64'(m_desc_tag), 64'h313);
    chk("bp_outstanding", 64'(outstanding), 64'd2);
    step();
    chk("bp_drained", 64'(m_desc_valid), 64'h0);
    status(0, 8'h10, 4'h0);
    status(3, 8'h13, 4'h0);

    // Status at zero count, then reset with a held descriptor.
    status(1, 8'h33, 4'h5);
    chk("z_outstanding", 64'(outstanding), 64'd0);
    chk("z_svalid", 64'(m_status_valid), 64'b0010);
    chk("z_stag", 64'(m_status_tag[15:8]), 64'h33);
    chk("z_serr", 64'(m_status_error[7:4]), 64'h5);
    m_desc_ready = 1'b0;
    s_desc_valid = 4'b0001;
    step();
    s_desc_valid = '0;
    chk("r_mvalid_pre", 64'(m_desc_valid), 64'h1);
    rst = 1'b1;
    s_status_tag = {2'd3, 8'h44}; s_status_valid = 1'b1;
    step();
    rst = 1'b0; s_status_valid = 1'b0; m_desc_ready = 1'b1;
    chk("r_mvalid", 64'(m_desc_valid), 64'h0);
    chk("r_outstanding", 64'(outstanding), 64'd0);
    chk("r_svalid", 64'(m_status_valid), 64'h0);
    chk("r_busy", 64'(busy), 64'h0);

    // enable=0 blocks grants.
    enable = 1'b0;
    s_desc_valid = 4'hF;
    #1 chk("en_ready", 64'(s_desc_ready), 64'h0);
    repeat (3) step();
    chk("en_mvalid", 64'(m_desc_valid), 64'h0);
    s_desc_valid = '0;
    enable = 1'b1;
    step();

    // Ports 1 and 3 contend.
    gq.delete();
    s_desc_valid = 4'b1010;
    repeat (6) step();
    s_desc_valid = '0;
    step();
    chk("pr_count", 64'(gq.size()), 64'd6);
    for (int i = 0; i < gq.size(); i++) begin
`ifdef DMA_DESC_ARB_FIXED_PRIO_EN
      chk($sformatf("pr_port%0d", i), 64'(gq[i]), 64'd1);
`else
      chk($sformatf("pr_port%0d", i), 64'(gq[i]), (i % 2 == 0) ? 64'd1 : 64'd3);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
